// File: rtl/ysyx_23060124_issue_ctrl_pkg.sv
// Shared definitions for the ysyx_23060124 issue controller: FSM state encodings
// and the architectural register count.
package ysyx_23060124_issue_ctrl_pkg;

  localparam int ysyx_23060124_REG_NUM = 32;

  typedef enum logic [1:0] {
    ysyx_23060124_ISSUE_RUN   = 2'd0,
    ysyx_23060124_ISSUE_DRAIN = 2'd1,
    ysyx_23060124_ISSUE_BLOCK = 2'd2
  } issue_state_e;

endpackage

// File: rtl/ysyx_23060124_issue_ctrl_scoreboard.sv
// Per-register pending-writeback bits with same-cycle writeback bypass.
// x0 is never tracked and always reads as not pending.
module ysyx_23060124_scoreboard #(
  parameter int NREG     = 32,
  parameter int REG_ADDR = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                set_en,
  input  logic [REG_ADDR-1:0] set_rd,
  input  logic                clr_en,
  input  logic [REG_ADDR-1:0] clr_rd,
  input  logic [REG_ADDR-1:0] rs1,
  input  logic [REG_ADDR-1:0] rs2,
  input  logic [REG_ADDR-1:0] rd,
  output logic [NREG-1:0]     busy,
  output logic                rs1_busy,
  output logic                rs2_busy,
  output logic                rd_busy,
  output logic                any_busy
);

  logic [NREG-1:0] sb_q;
  logic [NREG-1:0] sb_d;
  logic [NREG-1:0] clr_mask;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] sb_eff;

  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (clr_en && (clr_rd != '0)) clr_mask[clr_rd] = 1'b1;
    if (set_en && (set_rd != '0)) set_mask[set_rd] = 1'b1;
    // A writeback landing this cycle is treated as already complete.
    sb_eff   = sb_q & ~clr_mask;
    // Set is applied after clear so a new owner of the register wins.
    sb_d     = sb_eff | set_mask;
    rs1_busy = (rs1 != '0) & sb_eff[rs1];
    rs2_busy = (rs2 != '0) & sb_eff[rs2];
    rd_busy  = (rd  != '0) & sb_eff[rd];
    any_busy = |sb_eff;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sb_q <= '0;
    else        sb_q <= sb_d;
  end

  assign busy = sb_q;

endmodule

// File: rtl/ysyx_23060124_issue_ctrl.sv
// Decode-to-execute issue controller: RAW/WAW stalls via a scoreboard,
// serialisation of CSR/ecall/mret, and issue blocking until redirects resolve.
module ysyx_23060124_issue_ctrl
  import ysyx_23060124_issue_ctrl_pkg::*;
#(
  parameter int NREG     = ysyx_23060124_REG_NUM,
  parameter int REG_ADDR = 5,
  parameter int CNT_W    = 32
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_id_valid,
  output logic                o_id_ready,
  input  logic [REG_ADDR-1:0] i_rs1,
  input  logic [REG_ADDR-1:0] i_rs2,
  input  logic [REG_ADDR-1:0] i_rd,
  input  logic                i_wen,
  input  logic                i_ctrl_xfer,
  input  logic                i_serial,
  output logic                o_ex_valid,
  input  logic                i_ex_ready,
  input  logic                i_wb_valid,
  input  logic [REG_ADDR-1:0] i_wb_rd,
  input  logic                i_resolve_valid,
  input  logic                i_flush,
  output logic [NREG-1:0]     o_busy,
  output logic [CNT_W-1:0]    o_stall_cnt
);

  // Handshake: o_ex_valid is combinational from decode; an instruction moves
  // when o_ex_valid & i_ex_ready (fire), which is also reported as o_id_ready.
  // o_ex_valid only drops without a fire because of i_flush or reset.

  issue_state_e     state_q;
  issue_state_e     state_d;
  logic             en_q;
  logic             en_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;

  logic rs1_busy;
  logic rs2_busy;
  logic rd_busy;
  logic any_busy;
  logic hazard;
  logic allowed;
  logic fire;

  ysyx_23060124_scoreboard #(
    .NREG     (NREG),
    .REG_ADDR (REG_ADDR)
  ) u_scoreboard (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .set_en   (fire & i_wen),
    .set_rd   (i_rd),
    .clr_en   (i_wb_valid),
    .clr_rd   (i_wb_rd),
    .rs1      (i_rs1),
    .rs2      (i_rs2),
    .rd       (i_rd),
    .busy     (o_busy),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .rd_busy  (rd_busy),
    .any_busy (any_busy)
  );

  assign hazard = rs1_busy | rs2_busy | (i_wen & rd_busy);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ysyx_23060124_ISSUE_RUN;
      en_q        <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (i_flush) begin
      state_d = ysyx_23060124_ISSUE_RUN;
    end else if (fire) begin
      state_d = i_ctrl_xfer ? ysyx_23060124_ISSUE_BLOCK : ysyx_23060124_ISSUE_RUN;
    end else begin
      case (state_q)
        ysyx_23060124_ISSUE_RUN:
          if (i_id_valid && i_serial && any_busy) state_d = ysyx_23060124_ISSUE_DRAIN;
        ysyx_23060124_ISSUE_DRAIN:
          state_d = ysyx_23060124_ISSUE_DRAIN;
        ysyx_23060124_ISSUE_BLOCK:
          if (i_resolve_valid) state_d = ysyx_23060124_ISSUE_RUN;
        default:
          state_d = ysyx_23060124_ISSUE_RUN;
      endcase
    end
  end

  always_comb begin
    allowed = 1'b0;
    case (state_q)
      ysyx_23060124_ISSUE_RUN:   allowed = !hazard && !(i_serial && any_busy);
      // An empty effective scoreboard also rules out any hazard.
      ysyx_23060124_ISSUE_DRAIN: allowed = !any_busy;
      default:                   allowed = 1'b0;
    endcase
    o_ex_valid = en_q & i_id_valid & allowed & ~i_flush;
    fire       = o_ex_valid & i_ex_ready;
    o_id_ready = fire;
  end

  always_comb begin
    en_d        = 1'b1;
    stall_cnt_d = stall_cnt_q;
    if (i_id_valid && !fire && !i_flush && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign o_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_ysyx_23060124_issue_ctrl.sv
// Directed bench for the issue controller: expected issue outcomes are queued
// when an instruction is presented and popped when the DUT outputs are sampled.
module tb_ysyx_23060124_issue_ctrl;
  import ysyx_23060124_issue_ctrl_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        i_id_valid;
  logic        o_id_ready;
  logic [4:0]  i_rs1;
  logic [4:0]  i_rs2;
  logic [4:0]  i_rd;
  logic        i_wen;
  logic        i_ctrl_xfer;
  logic        i_serial;
  logic        o_ex_valid;
  logic        i_ex_ready;
  logic        i_wb_valid;
  logic [4:0]  i_wb_rd;
  logic        i_resolve_valid;
  logic        i_flush;
  logic [31:0] o_busy;
  logic [31:0] o_stall_cnt;

  int cmp_cnt;
  int mis_cnt;
  logic [31:0] exp_q[$];

  ysyx_23060124_issue_ctrl dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_id_valid      (i_id_valid),
    .o_id_ready      (o_id_ready),
    .i_rs1           (i_rs1),
    .i_rs2           (i_rs2),
    .i_rd            (i_rd),
    .i_wen           (i_wen),
    .i_ctrl_xfer     (i_ctrl_xfer),
    .i_serial        (i_serial),
    .o_ex_valid      (o_ex_valid),
    .i_ex_ready      (i_ex_ready),
    .i_wb_valid      (i_wb_valid),
    .i_wb_rd         (i_wb_rd),
    .i_resolve_valid (i_resolve_valid),
    .i_flush         (i_flush),
    .o_busy          (o_busy),
    .o_stall_cnt     (o_stall_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      mis_cnt++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_id_valid      = 1'b0;
    i_rs1           = '0;
    i_rs2           = '0;
    i_rd            = '0;
    i_wen           = 1'b0;
    i_ctrl_xfer     = 1'b0;
    i_serial        = 1'b0;
    i_ex_ready      = 1'b1;
    i_wb_valid      = 1'b0;
    i_wb_rd         = '0;
    i_resolve_valid = 1'b0;
    i_flush         = 1'b0;
  endtask

  // driver: present a decoded instruction and queue whether it should issue
  task automatic drive_inst(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic wen, input logic cx,
                            input logic ser, input logic exp_issue);
    i_id_valid  = v;
    i_rs1       = rs1;
    i_rs2       = rs2;
    i_rd        = rd;
    i_wen       = wen;
    i_ctrl_xfer = cx;
    i_serial    = ser;
    exp_q.push_back({31'd0, exp_issue});
  endtask

  task automatic sample_issue(input string tag);
    logic [31:0] e;
    #1;
    if (exp_q.size() == 0) begin
      cmp_cnt++;
      mis_cnt++;
      $display("FAIL %s: got %h expected <empty queue>", tag, o_ex_valid);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_valid"}, {31'd0, o_ex_valid}, e);
      chk({tag, "_ready"}, {31'd0, o_id_ready}, e & {31'd0, i_ex_ready});
    end
  endtask

  initial begin
    cmp_cnt = 0;
    mis_cnt = 0;
    idle();
    rst_n      = 1'b0;
    i_id_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ex_valid", {31'd0, o_ex_valid}, 32'd0);
    chk("rst_id_ready", {31'd0, o_id_ready}, 32'd0);
    chk("rst_busy", o_busy, 32'd0);
    chk("rst_stall", o_stall_cnt, 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(ysyx_23060124_ISSUE_RUN));
    idle();
    rst_n = 1'b1;
    step();

    // RAW stall with same-cycle writeback bypass
    drive_inst(1, 0, 0, 5, 1, 0, 0, 1); sample_issue("raw_first"); step();
    drive_inst(1, 5, 0, 6, 1, 0, 0, 0); sample_issue("raw_stall");
    chk("raw_busy", o_busy, 32'h20);
    step();
    chk("raw_stall_cnt", o_stall_cnt, 32'd1);
    drive_inst(1, 5, 0, 6, 1, 0, 0, 1);
    i_wb_valid = 1'b1; i_wb_rd = 5'd5;
    sample_issue("raw_wb_bypass"); step(); idle();
    chk("raw_busy_after", o_busy, 32'h40);
    chk("raw_stall_after", o_stall_cnt, 32'd1);
    i_wb_valid = 1'b1; i_wb_rd = 5'd6; step(); idle();
    chk("wb_clear6", o_busy, 32'd0);
    i_wb_valid = 1'b1; i_wb_rd = 5'd9; step(); idle();
    chk("wb_nonpending", o_busy, 32'd0);

    // x0 never tracked; set wins over same-cycle clear
    drive_inst(1, 0, 0, 0, 1, 0, 0, 1); sample_issue("x0_fire"); step(); idle();
    chk("x0_busy", o_busy, 32'd0);
    drive_inst(1, 0, 0, 7, 1, 0, 0, 1);
    i_wb_valid = 1'b1; i_wb_rd = 5'd7;
    sample_issue("setwin_fire"); step(); idle();
    chk("setwin_busy", o_busy, 32'h80);
    i_wb_valid = 1'b1; i_wb_rd = 5'd7; step(); idle();

    // serialise: drain x3, x4
    drive_inst(1, 0, 0, 3, 1, 0, 0, 1); sample_issue("ser_x3"); step();
    drive_inst(1, 0, 0, 4, 1, 0, 0, 1); sample_issue("ser_x4"); step(); idle();
    chk("ser_busy", o_busy, 32'h18);
    drive_inst(1, 0, 0, 0, 0, 0, 1, 0); sample_issue("ser_wait"); step();
    chk("ser_state_drain", 32'(dut.state_q), 32'(ysyx_23060124_ISSUE_DRAIN));
    drive_inst(1, 0, 0, 0, 0, 0, 1, 0);
    i_wb_valid = 1'b1; i_wb_rd = 5'd3;
    sample_issue("ser_wb3"); step();
    chk("ser_state_drain2", 32'(dut.state_q), 32'(ysyx_23060124_ISSUE_DRAIN));
    chk("ser_busy2", o_busy, 32'h10);
    drive_inst(1, 0, 0, 0, 0, 0, 1, 1);
    i_wb_rd = 5'd4;
    sample_issue("ser_go"); step(); idle();
    chk("ser_state_run", 32'(dut.state_q), 32'(ysyx_23060124_ISSUE_RUN));
    chk("ser_busy3", o_busy, 32'd0);
    chk("ser_stall", o_stall_cnt, 32'd3);

    // control transfer blocks until resolve
    drive_inst(1, 0, 0, 0, 0, 1, 0, 1); sample_issue("br_fire"); step();
    chk("br_state", 32'(dut.state_q), 32'(ysyx_23060124_ISSUE_BLOCK));
    for (int k = 0; k < 3; k++) begin
      drive_inst(1, 0, 0, 8, 1, 0, 0, 0); sample_issue("br_blocked"); step();
    end
    chk("br_stall", o_stall_cnt, 32'd6);
    drive_inst(1, 0, 0, 8, 1, 0, 0, 0);
    i_resolve_valid = 1'b1;
    sample_issue("br_resolve"); step();
    i_resolve_valid = 1'b0;
    chk("br_state_run", 32'(dut.state_q), 32'(ysyx_23060124_ISSUE_RUN));
    chk("br_stall2", o_stall_cnt, 32'd7);
    drive_inst(1, 0, 0, 8, 1, 0, 0, 1); sample_issue("br_after"); step(); idle();
    chk("br_busy", o_busy, 32'h100);
    i_wb_valid = 1'b1; i_wb_rd = 5'd8; step(); idle();

    // flush in BLOCK
    drive_inst(1, 0, 0, 5, 1, 1, 0, 1); sample_issue("jal_fire"); step();
    chk("jal_state", 32'(dut.state_q), 32'(ysyx_23060124_ISSUE_BLOCK));
    drive_inst(1, 0, 0, 9, 1, 0, 0, 0); sample_issue("jal_blocked"); step();
    drive_inst(1, 0, 0, 9, 1, 0, 0, 0);
    i_flush = 1'b1;
    sample_issue("flush"); step();
    i_flush = 1'b0;
    chk("flush_state", 32'(dut.state_q), 32'(ysyx_23060124_ISSUE_RUN));
    chk("flush_busy", o_busy, 32'h20);
    chk("flush_stall", o_stall_cnt, 32'd8);
    drive_inst(1, 5, 0, 9, 1, 0, 0, 0); sample_issue("hazard_x5"); step();
    chk("pre_rst_stall", o_stall_cnt, 32'd9);
    chk("pre_rst_busy", o_busy, 32'h20);

    // asynchronous reset between clock edges
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", o_busy, 32'd0);
    chk("arst_stall", o_stall_cnt, 32'd0);
    chk("arst_ex_valid", {31'd0, o_ex_valid}, 32'd0);
    chk("arst_id_ready", {31'd0, o_id_ready}, 32'd0);
    chk("arst_state", 32'(dut.state_q), 32'(ysyx_23060124_ISSUE_RUN));
    @(posedge clk); #1;
    idle();
    rst_n = 1'b1;
    step();

    // backpressure holds valid without consuming
    drive_inst(1, 5, 0, 9, 1, 0, 0, 1);
    i_ex_ready = 1'b0;
    sample_issue("bp_hold"); step();
    chk("bp_stall", o_stall_cnt, 32'd1);
    chk("bp_busy", o_busy, 32'd0);
    drive_inst(1, 5, 0, 9, 1, 0, 0, 1);
    i_ex_ready = 1'b1;
    sample_issue("bp_go"); step(); idle();
    chk("bp_busy2", o_busy, 32'h200);

    chk("exp_q_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule
